// File: rtl/rv32i_run_control.sv
// Run control for the RV32I core: turns divided-clock rising edges into core_ce
// pulses and gates them through reset hold, run, single-step and halt.
module rv32i_run_control #(
   parameter int unsigned RST_TICKS = 4
) (
   input  logic        clk_in,
   input  logic        rst_n,
   input  logic        div_clk,
   input  logic        run_sw,
   input  logic        step_btn,
   input  logic        halt_req,
   output logic        core_rst_n,
   output logic        core_ce,
   output logic        running,
   output logic        halt_flag,
   output logic [31:0] cycle_cnt
);

   typedef enum logic [1:0] {RESET_HOLD, HALTED, RUNNING, STEP} state_t;

   state_t      state, state_nxt;
   logic [2:0]  div_sync, step_sync;
   logic [1:0]  run_sync, halt_sync;
   logic        tick, step_pulse, run_sw_s, halt_req_s;
   logic [7:0]  tick_cnt, tick_cnt_nxt;
   logic [31:0] cnt_q, cnt_nxt;
   logic        core_rst_n_nxt, core_ce_nxt, running_nxt, halt_flag_nxt;
   logic        last_tick;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         div_sync  <= '0;
         step_sync <= '0;
         run_sync  <= '0;
         halt_sync <= '0;
      end else begin
         div_sync  <= {div_sync[1:0], div_clk};
         step_sync <= {step_sync[1:0], step_btn};
         run_sync  <= {run_sync[0], run_sw};
         halt_sync <= {halt_sync[0], halt_req};
      end
   end

   assign tick       = div_sync[1] & ~div_sync[2];
   assign step_pulse = step_sync[1] & ~step_sync[2];
   assign run_sw_s   = run_sync[1];
   assign halt_req_s = halt_sync[1];
   assign last_tick  = (tick_cnt == 8'(RST_TICKS - 1));
   assign cycle_cnt  = cnt_q;

   // State register together with the registered outputs
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RESET_HOLD;
         tick_cnt   <= '0;
         cnt_q      <= '0;
         core_rst_n <= 1'b0;
         core_ce    <= 1'b0;
         running    <= 1'b0;
         halt_flag  <= 1'b0;
      end else begin
         state      <= state_nxt;
         tick_cnt   <= tick_cnt_nxt;
         cnt_q      <= cnt_nxt;
         core_rst_n <= core_rst_n_nxt;
         core_ce    <= core_ce_nxt;
         running    <= running_nxt;
         halt_flag  <= halt_flag_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         RESET_HOLD: if (tick && last_tick) state_nxt = HALTED;
         HALTED: begin
            if (run_sw_s && !halt_flag) state_nxt = RUNNING;
            else if (step_pulse)        state_nxt = STEP;
         end
         RUNNING: if (halt_req_s || !run_sw_s) state_nxt = HALTED;
         STEP:    if (tick) state_nxt = HALTED;
         default: state_nxt = RESET_HOLD;
      endcase
   end

   always_comb begin
      core_ce_nxt    = 1'b0;
      core_rst_n_nxt = core_rst_n;
      halt_flag_nxt  = halt_flag;
      tick_cnt_nxt   = tick_cnt;
      cnt_nxt        = cnt_q;
      running_nxt    = (state_nxt == RUNNING);
      unique case (state)
         RESET_HOLD: begin
            core_rst_n_nxt = 1'b0;
            if (tick) begin
               if (last_tick) begin
                  core_rst_n_nxt = 1'b1;
                  tick_cnt_nxt   = '0;
               end else begin
                  tick_cnt_nxt = tick_cnt + 8'd1;
               end
            end
         end
         HALTED: if (!run_sw_s) halt_flag_nxt = 1'b0;
         // Halt wins over a coincident tick, so that tick never reaches the core
         RUNNING: begin
            if (halt_req_s)          halt_flag_nxt = 1'b1;
            else if (run_sw_s && tick) core_ce_nxt = 1'b1;
         end
         STEP:    if (tick) core_ce_nxt = 1'b1;
         default: core_rst_n_nxt = 1'b0;
      endcase
      if (state == RESET_HOLD) cnt_nxt = '0;
      else if (core_ce_nxt)    cnt_nxt = cnt_q + 32'd1;
   end

endmodule

// File: tb/tb_rv32i_run_control.sv
// Scoreboard bench for rv32i_run_control: a behavioural model predicts each core_ce
// pulse (edge number and cycle count) and a monitor checks what the DUT presents.
module tb_rv32i_run_control;

   localparam int unsigned RST_TICKS = 4;

   logic        clk_in = 1'b0;
   logic        rst_n = 1'b1;
   logic        div_clk = 1'b0;
   logic        run_sw = 1'b0;
   logic        step_btn = 1'b0;
   logic        halt_req = 1'b0;
   logic        core_rst_n, core_ce, running, halt_flag;
   logic [31:0] cycle_cnt;

   rv32i_run_control #(.RST_TICKS(RST_TICKS)) dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .div_clk    (div_clk),
      .run_sw     (run_sw),
      .step_btn   (step_btn),
      .halt_req   (halt_req),
      .core_rst_n (core_rst_n),
      .core_ce    (core_ce),
      .running    (running),
      .halt_flag  (halt_flag),
      .cycle_cnt  (cycle_cnt)
   );

   always #5 clk_in = ~clk_in;

   int unsigned cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      int unsigned at;
      logic [31:0] cnt;
   } exp_t;
   exp_t sb_q[$];

   // Abstract model: what the core sees, not how the block sequences it
   bit          m_released = 0;
   int unsigned m_ticks = 0;
   bit          m_run = 0;
   bit          m_halt = 0;
   bit          m_hreq = 0;
   bit          m_armed = 0;
   logic [31:0] m_cnt = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_ce(input int unsigned at);
      exp_t e;
      m_cnt  = m_cnt + 32'd1;
      e.at   = at;
      e.cnt  = m_cnt;
      sb_q.push_back(e);
   endtask

   task automatic model_rise(input int unsigned base, input bit coinc_step);
      bit can_arm;
      can_arm = m_released && !(m_run && !m_halt) && !m_armed;
      if (m_released) begin
         if (m_run && !m_halt) begin
            if (m_hreq) m_halt = 1;
            else        push_ce(base + 3);
         end else if (m_armed) begin
            m_armed = 0;
            push_ce(base + 3);
         end
      end
      if (coinc_step && can_arm) m_armed = 1;
   endtask

   always @(negedge clk_in) begin
      exp_t e;
      if (rst_n && core_ce) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ce_unexpected: got core_ce=1 at edge %0d expected none", cyc);
         end else begin
            e = sb_q.pop_front();
            check("ce_edge", cyc, e.at);
            check("ce_cycle_cnt", cycle_cnt, e.cnt);
         end
      end
   end

   task automatic div_period(input int unsigned hi, input int unsigned lo,
                             input bit coinc_halt, input bit coinc_step);
      @(negedge clk_in);
      if (coinc_halt) begin halt_req = 1'b1; m_hreq = 1; end
      if (coinc_step) step_btn = 1'b1;
      div_clk = 1'b1;
      model_rise(cyc, coinc_step);
      repeat (hi) @(negedge clk_in);
      div_clk  = 1'b0;
      step_btn = 1'b0;
      repeat (lo) @(negedge clk_in);
   endtask

   task automatic rand_periods(input int n);
      for (int i = 0; i < n; i++)
         div_period($urandom_range(2, 6), $urandom_range(4, 10), 0, 0);
   endtask

   task automatic step_press();
      @(negedge clk_in);
      step_btn = 1'b1;
      if (m_released && !(m_run && !m_halt)) m_armed = 1;
      repeat (3) @(negedge clk_in);
      step_btn = 1'b0;
      repeat (3) @(negedge clk_in);
   endtask

   task automatic reset_hold();
      int unsigned base;
      for (int i = 1; i <= int'(RST_TICKS); i++) begin
         @(negedge clk_in);
         div_clk = 1'b1;
         base = cyc;
         repeat (2) @(negedge clk_in);
         check("rst_hold_before", {31'b0, core_rst_n}, 32'd0);
         @(negedge clk_in);
         check("rst_release_edge", {31'b0, core_rst_n}, (i == int'(RST_TICKS)) ? 32'd1 : 32'd0);
         check("rst_hold_cnt", cycle_cnt, 32'd0);
         repeat (97) @(negedge clk_in);
         div_clk = 1'b0;
         repeat (99) @(negedge clk_in);
      end
      m_released = 1;
      m_cnt = '0;
      check("hold_running", {31'b0, running}, {31'b0, m_run});
      check("hold_halt_flag", {31'b0, halt_flag}, 32'd0);
      check("hold_cycle_cnt", cycle_cnt, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] snap;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk_in);
      check("reset_core_rst_n", {31'b0, core_rst_n}, 32'd0);
      check("reset_core_ce", {31'b0, core_ce}, 32'd0);
      check("reset_running", {31'b0, running}, 32'd0);
      check("reset_halt_flag", {31'b0, halt_flag}, 32'd0);
      check("reset_cycle_cnt", cycle_cnt, 32'd0);
      rst_n = 1'b1;
      reset_hold();

      // Free run
      run_sw = 1'b1; m_run = 1;
      repeat (5) @(negedge clk_in);
      rand_periods(10);
      repeat (5) @(negedge clk_in);
      check("free_cycle_cnt", cycle_cnt, 32'd10);
      check("free_running", {31'b0, running}, 32'd1);
      check("free_sb_drained", sb_q.size(), 32'd0);

      // Halt coincident with a tick
      div_period(4, 8, 1, 0);
      check("halt_flag_set", {31'b0, halt_flag}, 32'd1);
      check("halt_running", {31'b0, running}, 32'd0);
      halt_req = 1'b0; m_hreq = 0;
      snap = cycle_cnt;
      rand_periods(3);
      check("halt_held_cnt", cycle_cnt, snap);
      check("halt_held_flag", {31'b0, halt_flag}, 32'd1);
      run_sw = 1'b0; m_run = 0; m_halt = 0;
      repeat (5) @(negedge clk_in);
      check("halt_cleared", {31'b0, halt_flag}, 32'd0);
      run_sw = 1'b1; m_run = 1;
      repeat (5) @(negedge clk_in);
      rand_periods(5);
      check("resume_cycle_cnt", cycle_cnt, m_cnt);

      // Single step, including an ignored second press
      run_sw = 1'b0; m_run = 0;
      repeat (5) @(negedge clk_in);
      check("step_not_running", {31'b0, running}, 32'd0);
      snap = cycle_cnt;
      step_press();
      step_press();
      rand_periods(2);
      check("step_once", cycle_cnt, snap + 32'd1);
      // Step press coincident with a tick waits for the following tick
      div_period(3, 8, 0, 1);
      check("step_coinc_wait", cycle_cnt, snap + 32'd1);
      rand_periods(2);
      check("step_coinc_done", cycle_cnt, snap + 32'd2);

      // Wrap
      run_sw = 1'b1; m_run = 1;
      repeat (5) @(negedge clk_in);
      force dut.cnt_q = 32'hFFFF_FFFE;
      @(negedge clk_in);
      release dut.cnt_q;
      m_cnt = 32'hFFFF_FFFE;
      @(negedge clk_in);
      check("wrap_preset", cycle_cnt, 32'hFFFF_FFFE);
      rand_periods(3);
      check("wrap_final", cycle_cnt, 32'h0000_0001);

      // Reset during the core_ce cycle
      @(negedge clk_in);
      div_clk = 1'b1;
      model_rise(cyc, 0);
      repeat (3) @(negedge clk_in);
      check("midpulse_ce_high", {31'b0, core_ce}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("midpulse_ce", {31'b0, core_ce}, 32'd0);
      check("midpulse_core_rst_n", {31'b0, core_rst_n}, 32'd0);
      check("midpulse_cycle_cnt", cycle_cnt, 32'd0);
      div_clk = 1'b0;
      m_released = 0; m_ticks = 0; m_halt = 0; m_armed = 0; m_cnt = '0;
      repeat (4) @(negedge clk_in);
      rst_n = 1'b1;
      reset_hold();
      rand_periods(3);
      check("post_reset_cnt", cycle_cnt, 32'd3);

      repeat (20) @(negedge clk_in);
      check("final_sb_drained", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
